// File: rtl/dispatch_unit_pkg.sv
// Shared dispatch definitions: instruction-class codes, widths and bundles.
// Optional feature macro: DISPATCH_BYPASS_EN (forward CDB broadcasts into operands).
package dispatch_unit_pkg;

  localparam int RLEN = 32;
  localparam int RBID = 4;
  localparam int REGW = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0000011;
  localparam logic [6:0] OP_STYPE  = 7'b0100011;
  localparam logic [6:0] OP_ADDIOP = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  typedef struct packed {
    logic            rdy;
    logic [RLEN-1:0] val;
  } opnd_t;

  typedef struct packed {
    logic [5:0]      opcode;
    logic [6:0]      ophead;
    logic            rs1_ready;
    logic [RLEN-1:0] rs1_val;
    logic            rs2_ready;
    logic [RLEN-1:0] rs2_val;
    logic [RBID-1:0] rob_reorder;
  } rs_out_t;

  function automatic logic writes_rd(input logic [6:0] h);
    return !(h == OP_BRANCH || h == OP_STYPE);
  endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Decoder-to-dispatch handshake bundle.
// The decoder is the master; dispatch_unit is the slave.
interface dispatch_unit_if;
  import dispatch_unit_pkg::*;

  logic            dec_valid;
  logic            dec_ready;
  logic [6:0]      dec_ophead;
  logic [5:0]      dec_opcode;
  logic [REGW-1:0] dec_rd;
  logic [REGW-1:0] dec_rs1;
  logic [REGW-1:0] dec_rs2;
  logic [RLEN-1:0] dec_imm;
  logic [RLEN-1:0] dec_pc;

  modport master (
    output dec_valid, dec_ophead, dec_opcode,
    output dec_rd, dec_rs1, dec_rs2, dec_imm, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  dec_valid, dec_ophead, dec_opcode,
    input  dec_rd, dec_rs1, dec_rs2, dec_imm, dec_pc,
    output dec_ready
  );

endinterface

// File: rtl/dispatch_regstat.sv
// Register status table: value, busy and rename tag per architectural reg.
// Two async read ports, one rename write, one commit write, flush clears busy.
module dispatch_regstat
  import dispatch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic [REGW-1:0] ra1,
  input  logic [REGW-1:0] ra2,
  output logic [RLEN-1:0] rv1,
  output logic [RLEN-1:0] rv2,
  output logic            rb1,
  output logic            rb2,
  output logic [RBID-1:0] rt1,
  output logic [RBID-1:0] rt2,
  input  logic            ren_we,
  input  logic [REGW-1:0] ren_rd,
  input  logic [RBID-1:0] ren_tag,
  input  logic            cm_we,
  input  logic [REGW-1:0] cm_rd,
  input  logic [RBID-1:0] cm_tag,
  input  logic [RLEN-1:0] cm_val
);

  logic [RLEN-1:0] val_q [32];
  logic [RBID-1:0] tag_q [32];
  logic [31:0]     busy_q;
  logic [31:0]     busy_d;

  logic cm_en, ren_en;
  assign cm_en  = cm_we && (cm_rd != '0);
  assign ren_en = ren_we && (ren_rd != '0);

  // Rename is applied last so a same-cycle commit cannot clear a new tag.
  always_comb begin
    busy_d = busy_q;
    if (cm_en && tag_q[cm_rd] == cm_tag) busy_d[cm_rd] = 1'b0;
    if (flush) busy_d = '0;
    if (ren_en) busy_d[ren_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy) begin
      busy_q <= busy_d;
      if (cm_en) val_q[cm_rd] <= cm_val;
      if (ren_en) tag_q[ren_rd] <= ren_tag;
    end
  end

  assign rv1 = (ra1 == '0) ? '0 : val_q[ra1];
  assign rv2 = (ra2 == '0) ? '0 : val_q[ra2];
  assign rb1 = busy_q[ra1];
  assign rb2 = busy_q[ra2];
  assign rt1 = tag_q[ra1];
  assign rt2 = tag_q[ra2];

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: renames decoded ops, resolves operands, feeds the RS.
// Build option: DISPATCH_BYPASS_EN forwards CDB broadcasts instead of stalling.
module dispatch_unit
  import dispatch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  dispatch_unit_if.slave  dec,
  input  logic            rob_full,
  input  logic [RBID-1:0] rob_tag,
  output logic            rob_alloc,
  output logic [RBID-1:0] rob_q1_tag,
  output logic [RBID-1:0] rob_q2_tag,
  input  logic            rob_q1_ready,
  input  logic            rob_q2_ready,
  input  logic [RLEN-1:0] rob_q1_val,
  input  logic [RLEN-1:0] rob_q2_val,
  input  logic            commit_valid,
  input  logic [REGW-1:0] commit_rd,
  input  logic [RBID-1:0] commit_tag,
  input  logic [RLEN-1:0] commit_val,
  input  logic            flush,
  input  logic            alu_ans_flag,
  input  logic [RBID-1:0] alu_ans_reorder,
  input  logic [RLEN-1:0] alu_ans,
  input  logic            lsb_flag,
  input  logic [RBID-1:0] lsb_reorder,
  input  logic [RLEN-1:0] lsb_val,
  input  logic            rs_full,
  output logic            opflag,
  output logic [5:0]      opcode,
  output logic [6:0]      ophead,
  output logic            rs1_ready,
  output logic            rs2_ready,
  output logic [RLEN-1:0] rs1_val,
  output logic [RLEN-1:0] rs2_val,
  output logic [RBID-1:0] rob_reorder
);

  logic [RLEN-1:0] rv1, rv2;
  logic            rb1, rb2;
  logic [RBID-1:0] rt1, rt2;
  opnd_t           src1, src2, op1, op2;
  logic            use1, use2;
  logic            hazard_stall, accept;
  rs_out_t         out_q, out_d;
  logic            opflag_q;

  function automatic opnd_t resolve(
    input logic            busy,
    input logic [RBID-1:0] tag,
    input logic [RLEN-1:0] rval,
    input logic            qrdy,
    input logic [RLEN-1:0] qval
  );
    opnd_t r;
    r.rdy = 1'b1;
    r.val = rval;
    if (!busy) begin
    end else if (commit_valid && commit_tag == tag) begin
      r.val = commit_val;
`ifdef DISPATCH_BYPASS_EN
    end else if (alu_ans_flag && alu_ans_reorder == tag) begin
      r.val = alu_ans;
    end else if (lsb_flag && lsb_reorder == tag) begin
      r.val = lsb_val;
`endif
    end else if (qrdy) begin
      r.val = qval;
    end else begin
      r.rdy = 1'b0;
      r.val = {{(RLEN-RBID){1'b0}}, tag};
    end
    return r;
  endfunction

  always_comb begin
    src1 = resolve(rb1, rt1, rv1, rob_q1_ready, rob_q1_val);
    src2 = resolve(rb2, rt2, rv2, rob_q2_ready, rob_q2_val);
    use1 = 1'b1;
    use2 = 1'b0;
    op1  = src1;
    op2  = '{rdy: 1'b1, val: dec.dec_imm};
    unique case (1'b1)
      (dec.dec_ophead == OP_RTYPE),
      (dec.dec_ophead == OP_BRANCH),
      (dec.dec_ophead == OP_STYPE): begin
        use2 = 1'b1;
        op2  = src2;
      end
      (dec.dec_ophead == OP_LUI): begin
        use1 = 1'b0;
        op1  = '{rdy: 1'b1, val: '0};
      end
      (dec.dec_ophead == OP_AUIPC): begin
        use1 = 1'b0;
        op1  = '{rdy: 1'b1, val: dec.dec_pc};
      end
      (dec.dec_ophead == OP_JAL): begin
        use1 = 1'b0;
        op1  = '{rdy: 1'b1, val: dec.dec_pc};
        op2  = '{rdy: 1'b1, val: 32'd4};
      end
      default: ;
    endcase
  end

`ifdef DISPATCH_BYPASS_EN
  assign hazard_stall = 1'b0 & use1 & use2;
`else
  function automatic logic bc_hit(input logic [RBID-1:0] t);
    return (alu_ans_flag && alu_ans_reorder == t) ||
           (lsb_flag && lsb_reorder == t);
  endfunction

  // A broadcast seen now is gone next cycle; retry when the ROB holds it.
  assign hazard_stall = (use1 && !src1.rdy && bc_hit(rt1)) ||
                        (use2 && !src2.rdy && bc_hit(rt2));
`endif

  assign dec.dec_ready = rst & rdy & !rs_full & !rob_full &
                         !flush & !hazard_stall;
  assign accept     = dec.dec_valid & dec.dec_ready;
  assign rob_alloc  = accept;
  assign rob_q1_tag = rt1;
  assign rob_q2_tag = rt2;

  always_comb begin
    out_d = out_q;
    if (accept) begin
      out_d.opcode      = dec.dec_opcode;
      out_d.ophead      = dec.dec_ophead;
      out_d.rs1_ready   = op1.rdy;
      out_d.rs1_val     = op1.val;
      out_d.rs2_ready   = op2.rdy;
      out_d.rs2_val     = op2.val;
      out_d.rob_reorder = rob_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      opflag_q <= 1'b0;
      out_q    <= '0;
    end else begin
      opflag_q <= accept;
      out_q    <= out_d;
    end
  end

  dispatch_regstat u_regstat (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .flush   (flush),
    .ra1     (dec.dec_rs1),
    .ra2     (dec.dec_rs2),
    .rv1     (rv1),
    .rv2     (rv2),
    .rb1     (rb1),
    .rb2     (rb2),
    .rt1     (rt1),
    .rt2     (rt2),
    .ren_we  (accept && writes_rd(dec.dec_ophead)),
    .ren_rd  (dec.dec_rd),
    .ren_tag (rob_tag),
    .cm_we   (commit_valid),
    .cm_rd   (commit_rd),
    .cm_tag  (commit_tag),
    .cm_val  (commit_val)
  );

  assign opflag      = opflag_q;
  assign opcode      = out_q.opcode;
  assign ophead      = out_q.ophead;
  assign rs1_ready   = out_q.rs1_ready;
  assign rs1_val     = out_q.rs1_val;
  assign rs2_ready   = out_q.rs2_ready;
  assign rs2_val     = out_q.rs2_val;
  assign rob_reorder = out_q.rob_reorder;

endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: directed scenarios then random traffic
// against an array-based model of the register status table.
module tb_dispatch_unit;
  import dispatch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        rob_full, rob_alloc;
  logic [3:0]  rob_tag, rob_q1_tag, rob_q2_tag;
  logic        rob_q1_ready, rob_q2_ready;
  logic [31:0] rob_q1_val, rob_q2_val;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic [31:0] commit_val;
  logic        flush;
  logic        alu_ans_flag, lsb_flag;
  logic [3:0]  alu_ans_reorder, lsb_reorder;
  logic [31:0] alu_ans, lsb_val;
  logic        rs_full, opflag, rs1_ready, rs2_ready;
  logic [5:0]  opcode;
  logic [6:0]  ophead;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  rob_reorder;

  dispatch_unit_if dif();

  dispatch_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .dec(dif.slave),
    .rob_full(rob_full), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
    .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
    .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
    .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_val(commit_val), .flush(flush),
    .alu_ans_flag(alu_ans_flag), .alu_ans_reorder(alu_ans_reorder),
    .alu_ans(alu_ans), .lsb_flag(lsb_flag), .lsb_reorder(lsb_reorder),
    .lsb_val(lsb_val), .rs_full(rs_full), .opflag(opflag),
    .opcode(opcode), .ophead(ophead), .rs1_ready(rs1_ready),
    .rs2_ready(rs2_ready), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rob_reorder(rob_reorder)
  );

  always #5 clk = ~clk;

`ifdef DISPATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          rdy;
    logic [31:0] v;
    bit          hz;
  } src_t;

  typedef struct {
    logic [5:0]  opc;
    logic [6:0]  oph;
    bit          r1;
    logic [31:0] v1;
    bit          r2;
    logic [31:0] v2;
    logic [3:0]  tag;
  } exp_t;

  logic [31:0] m_val [32];
  bit          m_busy [32];
  logic [3:0]  m_tag [32];
  exp_t        sbq [$];
  int          n_tests = 0;
  int          n_fail = 0;

  logic [6:0] OPS [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_ITYPE, OP_STYPE, OP_ADDIOP, OP_RTYPE};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic src_t look(input int r, input bit qr,
                                input logic [31:0] qv);
    src_t s;
    bit alu_hit, lsb_hit;
    alu_hit = alu_ans_flag && alu_ans_reorder == m_tag[r];
    lsb_hit = lsb_flag && lsb_reorder == m_tag[r];
    s.hz = 1'b0;
    s.rdy = 1'b1;
    if (r == 0) s.v = 32'd0;
    else if (!m_busy[r]) s.v = m_val[r];
    else if (commit_valid && commit_tag == m_tag[r]) s.v = commit_val;
    else if (BYP && alu_hit) s.v = alu_ans;
    else if (BYP && lsb_hit) s.v = lsb_val;
    else if (qr) s.v = qv;
    else begin
      s.rdy = 1'b0;
      s.v = {28'd0, m_tag[r]};
      s.hz = alu_hit || lsb_hit;
    end
    return s;
  endfunction

  task automatic cycle();
    src_t a, b;
    exp_t e;
    bit u1, u2, hz, er, acc;
    logic [6:0] h;
    int rd;
    #1;
    h = dif.dec_ophead;
    a = look(int'(dif.dec_rs1), rob_q1_ready, rob_q1_val);
    b = look(int'(dif.dec_rs2), rob_q2_ready, rob_q2_val);
    e.opc = dif.dec_opcode;
    e.oph = h;
    e.tag = rob_tag;
    u1 = 1'b1;
    u2 = 1'b0;
    e.r1 = a.rdy;
    e.v1 = a.v;
    e.r2 = 1'b1;
    e.v2 = dif.dec_imm;
    if (h == OP_RTYPE || h == OP_BRANCH || h == OP_STYPE) begin
      u2 = 1'b1;
      e.r2 = b.rdy;
      e.v2 = b.v;
    end else if (h == OP_LUI) begin
      u1 = 1'b0; e.r1 = 1'b1; e.v1 = 32'd0;
    end else if (h == OP_AUIPC) begin
      u1 = 1'b0; e.r1 = 1'b1; e.v1 = dif.dec_pc;
    end else if (h == OP_JAL) begin
      u1 = 1'b0; e.r1 = 1'b1; e.v1 = dif.dec_pc; e.v2 = 32'd4;
    end
    hz = !BYP && ((u1 && a.hz) || (u2 && b.hz));
    er = rst && rdy && !rs_full && !rob_full && !flush && !hz;
    acc = er && dif.dec_valid;
    chk("dec_ready", 32'(dif.dec_ready), 32'(er));
    chk("rob_alloc", 32'(rob_alloc), 32'(acc));
    chk("rob_q1_tag", 32'(rob_q1_tag), 32'(m_tag[dif.dec_rs1]));
    chk("rob_q2_tag", 32'(rob_q2_tag), 32'(m_tag[dif.dec_rs2]));
    if (acc) sbq.push_back(e);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy) begin
      rd = int'(commit_rd);
      if (commit_valid && rd != 0) begin
        m_val[rd] = commit_val;
        if (m_tag[rd] == commit_tag) m_busy[rd] = 1'b0;
      end
      if (flush)
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      rd = int'(dif.dec_rd);
      if (acc && rd != 0 && h != OP_BRANCH && h != OP_STYPE) begin
        m_busy[rd] = 1'b1;
        m_tag[rd] = rob_tag;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; rdy = 1'b1;
    dif.dec_valid = 1'b0; dif.dec_ophead = OP_ADDIOP; dif.dec_opcode = '0;
    dif.dec_rd = '0; dif.dec_rs1 = '0; dif.dec_rs2 = '0;
    dif.dec_imm = '0; dif.dec_pc = '0;
    rob_full = 1'b0; rob_tag = '0;
    rob_q1_ready = 1'b0; rob_q2_ready = 1'b0;
    rob_q1_val = '0; rob_q2_val = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_val = '0;
    flush = 1'b0; rs_full = 1'b0;
    alu_ans_flag = 1'b0; alu_ans_reorder = '0; alu_ans = '0;
    lsb_flag = 1'b0; lsb_reorder = '0; lsb_val = '0;
  endtask

  task automatic issue(input logic [6:0] h, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] imm, input logic [3:0] t);
    dif.dec_valid = 1'b1; dif.dec_ophead = h;
    dif.dec_opcode = 6'(h);
    dif.dec_rd = rd; dif.dec_rs1 = r1; dif.dec_rs2 = r2;
    dif.dec_imm = imm; rob_tag = t;
  endtask

  task automatic rand_in();
    rst = ($urandom_range(0, 199) != 0);
    rdy = ($urandom_range(0, 19) != 0);
    dif.dec_valid = ($urandom_range(0, 3) != 0);
    dif.dec_ophead = OPS[$urandom_range(0, 8)];
    dif.dec_opcode = 6'($urandom);
    dif.dec_rd = 5'($urandom_range(0, 7));
    dif.dec_rs1 = 5'($urandom_range(0, 7));
    dif.dec_rs2 = 5'($urandom_range(0, 7));
    dif.dec_imm = $urandom;
    dif.dec_pc = $urandom;
    rs_full = ($urandom_range(0, 7) == 0);
    rob_full = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 24) == 0);
    rob_tag = 4'($urandom);
    rob_q1_ready = ($urandom_range(0, 2) == 0);
    rob_q2_ready = ($urandom_range(0, 2) == 0);
    rob_q1_val = $urandom;
    rob_q2_val = $urandom;
    commit_valid = ($urandom_range(0, 1) == 0);
    commit_rd = 5'($urandom_range(0, 7));
    commit_tag = ($urandom_range(0, 1) == 0) ?
                 m_tag[$urandom_range(0, 7)] : 4'($urandom);
    commit_val = $urandom;
    alu_ans_flag = ($urandom_range(0, 1) == 0);
    alu_ans_reorder = m_tag[$urandom_range(0, 7)];
    alu_ans = $urandom;
    lsb_flag = ($urandom_range(0, 2) == 0);
    lsb_reorder = ($urandom_range(0, 1) == 0) ?
                  m_tag[$urandom_range(0, 7)] : 4'($urandom);
    lsb_val = $urandom;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (opflag === 1'b1) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_dispatch: got opflag 1 expected 0");
        end else begin
          e = sbq.pop_front();
          chk("opcode", 32'(opcode), 32'(e.opc));
          chk("ophead", 32'(ophead), 32'(e.oph));
          chk("rs1_ready", 32'(rs1_ready), 32'(e.r1));
          chk("rs1_val", rs1_val, e.v1);
          chk("rs2_ready", 32'(rs2_ready), 32'(e.r2));
          chk("rs2_val", rs2_val, e.v2);
          chk("rob_reorder", 32'(rob_reorder), 32'(e.tag));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    idle();
    rst = 1'b0;
    dif.dec_valid = 1'b1;
    cycle();
    cycle();
    chk("rst_opflag", 32'(opflag), 32'd0);
    chk("rst_rs1_val", rs1_val, 32'd0);
    chk("rst_rs2_val", rs2_val, 32'd0);
    chk("rst_rob_reorder", 32'(rob_reorder), 32'd0);
    idle();

    issue(OP_ADDIOP, 5'd1, 5'd0, 5'd0, 32'd5, 4'd3);
    cycle();
    chk("addi_opflag", 32'(opflag), 32'd1);
    chk("addi_rs1", rs1_val, 32'd0);
    chk("addi_rs2", rs2_val, 32'd5);
    chk("addi_rs2_rdy", 32'(rs2_ready), 32'd1);
    chk("addi_tag", 32'(rob_reorder), 32'd3);
    idle();

    issue(OP_RTYPE, 5'd2, 5'd1, 5'd1, 32'd0, 4'd4);
    #1 chk("x1_tag", 32'(rob_q1_tag), 32'd3);
    cycle();
    chk("add_rs1", rs1_val, 32'd3);
    chk("add_rs2", rs2_val, 32'd3);
    chk("add_rdy", 32'({rs1_ready, rs2_ready}), 32'd0);
    idle();

    issue(OP_RTYPE, 5'd6, 5'd1, 5'd1, 32'd0, 4'd6);
    alu_ans_flag = 1'b1; alu_ans_reorder = 4'd3; alu_ans = 32'd7;
`ifdef DISPATCH_BYPASS_EN
    cycle();
`else
    cycle();
    chk("stall_opflag", 32'(opflag), 32'd0);
    alu_ans_flag = 1'b0;
    rob_q1_ready = 1'b1; rob_q1_val = 32'd7;
    rob_q2_ready = 1'b1; rob_q2_val = 32'd7;
    cycle();
`endif
    chk("bc_rs1", rs1_val, 32'd7);
    chk("bc_rs2", rs2_val, 32'd7);
    chk("bc_rdy", 32'({rs1_ready, rs2_ready}), 32'd3);
    idle();

    issue(OP_ADDIOP, 5'd7, 5'd0, 5'd0, 32'd1, 4'd8);
    rs_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("full_opflag", 32'(opflag), 32'd0);
    end
    rs_full = 1'b0;
    cycle();
    chk("release_opflag", 32'(opflag), 32'd1);
    dif.dec_valid = 1'b0;
    cycle();
    chk("single_opflag", 32'(opflag), 32'd0);
    idle();

    issue(OP_ADDIOP, 5'd1, 5'd0, 5'd0, 32'd2, 4'd5);
    commit_valid = 1'b1; commit_rd = 5'd1;
    commit_tag = 4'd3; commit_val = 32'd9;
    cycle();
    idle();
    issue(OP_RTYPE, 5'd2, 5'd1, 5'd1, 32'd0, 4'd9);
    cycle();
    chk("rename_rs1", rs1_val, 32'd5);
    chk("rename_rdy", 32'(rs1_ready), 32'd0);
    idle();

    issue(OP_ADDIOP, 5'd3, 5'd0, 5'd0, 32'd0, 4'd10);
    cycle();
    issue(OP_ADDIOP, 5'd4, 5'd0, 5'd0, 32'd0, 4'd11);
    cycle();
    idle();
    commit_valid = 1'b1; commit_rd = 5'd3;
    commit_tag = 4'd15; commit_val = 32'd33;
    cycle();
    flush = 1'b1; commit_rd = 5'd4;
    commit_tag = 4'd2; commit_val = 32'd44;
    cycle();
    idle();
    issue(OP_RTYPE, 5'd5, 5'd3, 5'd4, 32'd0, 4'd12);
    cycle();
    chk("flush_rs1", rs1_val, 32'd33);
    chk("flush_rs2", rs2_val, 32'd44);
    chk("flush_rdy", 32'({rs1_ready, rs2_ready}), 32'd3);
    idle();

    rdy = 1'b0;
    issue(OP_LUI, 5'd8, 5'd0, 5'd0, 32'h1000, 4'd1);
    cycle();
    cycle();
    chk("frozen_opflag", 32'(opflag), 32'd0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      rand_in();
      cycle();
    end
    idle();
    dif.dec_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
